// File: rtl/frame_pkg.sv
// Constants and state encoding shared by the frame generator and the deframer.
package frame_pkg;

    localparam logic [7:0] SOF_BYTE = 8'h7E;
    localparam logic [7:0] EOF_BYTE = 8'h7F;
    localparam logic [7:0] PAD_BYTE = 8'h00;

    localparam int MIN_FRAME_SIZE     = 64;
    localparam int DEF_PAYLOAD_LEN    = 16;
    localparam int DEF_MAX_FRAME_SIZE = 255;
    localparam int DEF_TIMEOUT        = 15;

    typedef enum logic [1:0] {
        HUNT    = 2'd0,
        PAYLOAD = 2'd1,
        PAD     = 2'd2
    } state_t;

endpackage

// File: rtl/frame_deframer_if.sv
// Byte-stream input and frame-result outputs of the deframer, plus FSM state for checkers.
interface frame_deframer_if #(
    parameter int PAYLOAD_LEN = 16
);
    import frame_pkg::*;

    // Handshake: in_data is consumed on every rising clk edge where in_valid=1;
    // there is no ready, the receiver never stalls the source.
    logic [7:0]               in_data;
    logic                     in_valid;

    logic [8*PAYLOAD_LEN-1:0] payload_out;
    logic                     frame_valid;
    logic [7:0]               frame_len_out;
    logic [7:0]               pad_count;
    logic                     err_short;
    logic                     err_long;
    logic                     err_pad;
    logic                     err_timeout;
    logic                     busy;
    logic [15:0]              frame_count;
    logic [15:0]              err_count;
    state_t                   state_dbg;

    modport master (
        output in_data, in_valid,
        input  payload_out, frame_valid, frame_len_out, pad_count,
               err_short, err_long, err_pad, err_timeout, busy,
               frame_count, err_count, state_dbg
    );

    modport slave (
        input  in_data, in_valid,
        output payload_out, frame_valid, frame_len_out, pad_count,
               err_short, err_long, err_pad, err_timeout, busy,
               frame_count, err_count, state_dbg
    );

endinterface

// File: rtl/frame_deframer_sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (inc && (count != {WIDTH{1'b1}})) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/frame_deframer.sv
// Receive-side deframer: hunts SOF, captures a fixed payload, skips padding to EOF,
// checks length limits and idle timeout, and reports results as registered pulses.
module frame_deframer #(
    parameter int PAYLOAD_LEN    = frame_pkg::DEF_PAYLOAD_LEN,
    parameter int MIN_FRAME_SIZE = frame_pkg::MIN_FRAME_SIZE,
    parameter int MAX_FRAME_SIZE = frame_pkg::DEF_MAX_FRAME_SIZE,
    parameter int TIMEOUT        = frame_pkg::DEF_TIMEOUT
) (
    input  logic             clk,
    input  logic             reset,
    frame_deframer_if.slave  bus
);
    import frame_pkg::*;

    localparam logic [7:0] MIN_LEN  = 8'(MIN_FRAME_SIZE);
    localparam logic [7:0] MAX_LEN  = 8'(MAX_FRAME_SIZE);
    localparam logic [7:0] IDLE_MAX = 8'(TIMEOUT);
    localparam logic [5:0] LAST_IDX = 6'(PAYLOAD_LEN - 1);

    state_t                   state, state_nx;
    logic [7:0]               len, len_nx, len_inc;
    logic [7:0]               pads, pads_nx;
    logic [7:0]               idle_cnt, idle_nx;
    logic [5:0]               idx, idx_nx;
    logic [8*PAYLOAD_LEN-1:0] cap_buf;
    logic                     cap_we, load_out;
    logic                     fv_nx, es_nx, el_nx, ep_nx, et_nx;

    logic [8*PAYLOAD_LEN-1:0] payload_q;
    logic [7:0]               frame_len_q, pad_count_q;
    logic                     fv_q, es_q, el_q, ep_q, et_q;

    always_comb begin
        state_nx = state;
        len_nx   = len;
        pads_nx  = pads;
        idle_nx  = idle_cnt;
        idx_nx   = idx;
        cap_we   = 1'b0;
        load_out = 1'b0;
        fv_nx    = 1'b0;
        es_nx    = 1'b0;
        el_nx    = 1'b0;
        ep_nx    = 1'b0;
        et_nx    = 1'b0;
        len_inc  = len + 8'd1;

        if (state != HUNT && !bus.in_valid) begin
            idle_nx = idle_cnt + 8'd1;
            if (idle_nx == IDLE_MAX) begin
                et_nx    = 1'b1;
                state_nx = HUNT;
            end
        end else if (bus.in_valid) begin
            unique case (state)
                HUNT: begin
                    if (bus.in_data == SOF_BYTE) begin
                        state_nx = PAYLOAD;
                        len_nx   = 8'd1;
                        idx_nx   = '0;
                        pads_nx  = '0;
                        idle_nx  = '0;
                    end
                end
                PAYLOAD: begin
                    // Marker values are ordinary data inside the payload window.
                    idle_nx = '0;
                    cap_we  = 1'b1;
                    idx_nx  = idx + 6'd1;
                    len_nx  = len_inc;
                    if (len_inc >= MAX_LEN) begin
                        el_nx    = 1'b1;
                        state_nx = HUNT;
                    end else if (idx == LAST_IDX) begin
                        state_nx = PAD;
                    end
                end
                PAD: begin
                    idle_nx = '0;
                    len_nx  = len_inc;
                    if (bus.in_data == EOF_BYTE) begin
                        state_nx = HUNT;
                        if (len_inc >= MIN_LEN) begin
                            fv_nx    = 1'b1;
                            load_out = 1'b1;
                        end else begin
                            es_nx = 1'b1;
                        end
                    end else if (len_inc >= MAX_LEN) begin
                        el_nx    = 1'b1;
                        state_nx = HUNT;
                    end else if (bus.in_data == PAD_BYTE) begin
                        pads_nx = pads + 8'd1;
                    end else if (bus.in_data == SOF_BYTE) begin
                        // A stray SOF both flags the bad frame and opens a new one.
                        ep_nx    = 1'b1;
                        state_nx = PAYLOAD;
                        len_nx   = 8'd1;
                        idx_nx   = '0;
                        pads_nx  = '0;
                    end else begin
                        ep_nx    = 1'b1;
                        state_nx = HUNT;
                    end
                end
                default: state_nx = HUNT;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= HUNT;
            len         <= '0;
            pads        <= '0;
            idle_cnt    <= '0;
            idx         <= '0;
            cap_buf     <= '0;
            payload_q   <= '0;
            frame_len_q <= '0;
            pad_count_q <= '0;
            fv_q        <= 1'b0;
            es_q        <= 1'b0;
            el_q        <= 1'b0;
            ep_q        <= 1'b0;
            et_q        <= 1'b0;
        end else begin
            state    <= state_nx;
            len      <= len_nx;
            pads     <= pads_nx;
            idle_cnt <= idle_nx;
            idx      <= idx_nx;
            if (cap_we) begin
                cap_buf[int'(idx)*8 +: 8] <= bus.in_data;
            end
            if (load_out) begin
                payload_q   <= cap_buf;
                frame_len_q <= len_inc;
                pad_count_q <= pads;
            end
            fv_q <= fv_nx;
            es_q <= es_nx;
            el_q <= el_nx;
            ep_q <= ep_nx;
            et_q <= et_nx;
        end
    end

    // Counters take the next-cycle pulses so they update together with the strobes.
    sat_counter #(.WIDTH(16)) u_frame_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (fv_nx),
        .count (bus.frame_count)
    );

    sat_counter #(.WIDTH(16)) u_err_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (es_nx | el_nx | ep_nx | et_nx),
        .count (bus.err_count)
    );

    assign bus.payload_out   = payload_q;
    assign bus.frame_valid   = fv_q;
    assign bus.frame_len_out = frame_len_q;
    assign bus.pad_count     = pad_count_q;
    assign bus.err_short     = es_q;
    assign bus.err_long      = el_q;
    assign bus.err_pad       = ep_q;
    assign bus.err_timeout   = et_q;
    assign bus.busy          = (state != HUNT);
    assign bus.state_dbg     = state;

endmodule
